// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480 timing constants, 332 colour field positions
// and helper types used by the scan driver and the screens feeding it.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W  = 11;
    localparam int COLOUR_W = 8;
    localparam int CHAN_W   = 4;
    localparam int FRAME_W  = 16;

    // RRRGGGBB field positions inside an 8-bit renderer colour
    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } syncBits_t;

    // Blanked, both syncs inactive (high)
    localparam syncBits_t SYNC_IDLE = '{1'b0, 1'b1, 1'b1};

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb444_t;

    // Replicate the top bits so full-scale 332 maps to full-scale 444
    function automatic rgb444_t expand332(input logic [COLOUR_W-1:0] c);
        rgb444_t o;
        o.r = {c[R_HI:R_LO], c[R_HI]};
        o.g = {c[G_HI:G_LO], c[G_HI]};
        o.b = {c[B_HI:B_LO], c[B_HI:B_LO]};
        return o;
    endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// vga_scan_driver_if: bundle between the scan driver (master) and the
// renderer / monitor side (slave): coordinates, colour in, VGA pins out.
interface vga_scan_driver_if;
    import vga_pkg::*;

    logic [COLOUR_W-1:0] RGB_in;
    logic [COORD_W-1:0]  pixelX;
    logic [COORD_W-1:0]  pixelY;
    logic                startOfFrame;
    logic [CHAN_W-1:0]   vga_r;
    logic [CHAN_W-1:0]   vga_g;
    logic [CHAN_W-1:0]   vga_b;
    logic                vga_hs;
    logic                vga_vs;
    logic [FRAME_W-1:0]  frameCount;

    modport master (
        input  RGB_in,
        output pixelX, pixelY, startOfFrame,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs,
        output frameCount
    );

    modport slave (
        output RGB_in,
        input  pixelX, pixelY, startOfFrame,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs,
        input  frameCount
    );

endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register with enable and reset value.
// Ports: clk, reset (sync, high), shiftEn, dIn -> dOut. DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shiftEn,
    input  logic [WIDTH-1:0] dIn,
    output logic [WIDTH-1:0] dOut
);

    generate
        if (DEPTH == 0) begin : gPass
            logic unusedInputs;
            assign unusedInputs = &{1'b0, clk, reset, shiftEn};
            assign dOut = dIn;
        end else begin : gShift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++)
                        stages[i] <= RESET_VAL;
                end else if (shiftEn) begin
                    stages[0] <= dIn;
                    for (int i = 1; i < DEPTH; i++)
                        stages[i] <= stages[i-1];
                end
            end

            assign dOut = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: pixel divider, X/Y scan counters, frame pulse/count,
// aligned sync + 332->444 colour outputs. Ports: clk, reset, bus (master).
module vga_scan_driver #(
    parameter int CLK_DIV     = 2,
    parameter int RGB_LATENCY = 2,
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int H_FP        = vga_pkg::H_FP,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_BP        = vga_pkg::H_BP,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int V_FP        = vga_pkg::V_FP,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_BP        = vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              reset,
    vga_scan_driver_if.master bus
);
    import vga_pkg::*;

    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [1:0]         divCnt;
    logic               pixTick;
    logic [COORD_W-1:0] pixelX;
    logic [COORD_W-1:0] pixelY;
    logic [COORD_W-1:0] xNext;
    logic [COORD_W-1:0] yNext;
    logic               sof;
    logic [FRAME_W-1:0] frameCount;
    syncBits_t          rawSync;
    syncBits_t          dlySync;
    rgb444_t            colour;
    logic [CHAN_W-1:0]  vgaR;
    logic [CHAN_W-1:0]  vgaG;
    logic [CHAN_W-1:0]  vgaB;
    logic               vgaHs;
    logic               vgaVs;

    // With CLK_DIV=1 the compare is against 0 and divCnt never moves,
    // so pixTick stays high every clk.
    assign pixTick = (divCnt == 2'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)
            divCnt <= '0;
        else if (pixTick)
            divCnt <= '0;
        else
            divCnt <= divCnt + 2'd1;
    end

    always_comb begin
        xNext = pixelX;
        yNext = pixelY;
        if (pixTick) begin
            if (pixelX == COORD_W'(H_TOT - 1)) begin
                xNext = '0;
                if (pixelY == COORD_W'(V_TOT - 1))
                    yNext = '0;
                else
                    yNext = pixelY + 1'b1;
            end else begin
                xNext = pixelX + 1'b1;
            end
        end
    end

    // The pulse is registered alongside the counters, so it is high for
    // the single clk in which they first read (0, V_ACTIVE).
    always_ff @(posedge clk) begin
        if (reset) begin
            pixelX     <= '0;
            pixelY     <= '0;
            sof        <= 1'b0;
            frameCount <= '0;
        end else begin
            pixelX <= xNext;
            pixelY <= yNext;
            sof    <= 1'b0;
            if (pixTick && xNext == '0 &&
                yNext == COORD_W'(V_ACTIVE)) begin
                sof        <= 1'b1;
                frameCount <= frameCount + 1'b1;
            end
        end
    end

    always_comb begin
        rawSync.active = (pixelX < COORD_W'(H_ACTIVE)) &&
                         (pixelY < COORD_W'(V_ACTIVE));
        rawSync.hs = !((pixelX >= COORD_W'(HS_START)) &&
                       (pixelX <  COORD_W'(HS_END)));
        rawSync.vs = !((pixelY >= COORD_W'(VS_START)) &&
                       (pixelY <  COORD_W'(VS_END)));
    end

    // Delays timing by the renderer latency so it lines up with RGB_in
    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (RGB_LATENCY),
        .RESET_VAL (SYNC_IDLE)
    ) uSyncDelay (
        .clk     (clk),
        .reset   (reset),
        .shiftEn (pixTick),
        .dIn     (rawSync),
        .dOut    (dlySync)
    );

    assign colour = expand332(bus.RGB_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            vgaR  <= '0;
            vgaG  <= '0;
            vgaB  <= '0;
            vgaHs <= 1'b1;
            vgaVs <= 1'b1;
        end else if (pixTick) begin
            vgaR  <= dlySync.active ? colour.r : '0;
            vgaG  <= dlySync.active ? colour.g : '0;
            vgaB  <= dlySync.active ? colour.b : '0;
            vgaHs <= dlySync.hs;
            vgaVs <= dlySync.vs;
        end
    end

    assign bus.pixelX       = pixelX;
    assign bus.pixelY       = pixelY;
    assign bus.startOfFrame = sof;
    assign bus.frameCount   = frameCount;
    assign bus.vga_r        = vgaR;
    assign bus.vga_g        = vgaG;
    assign bus.vga_b        = vgaB;
    assign bus.vga_hs       = vgaHs;
    assign bus.vga_vs       = vgaVs;

endmodule
